// File: rtl/ctrl_unit_seq_if.sv
// Fetch-side bundle for the sequenced control unit:
// instruction and memory-busy in, registered datapath controls out.
interface ctrl_unit_seq_if #(
    parameter int ALUOP_W = 3
);
    logic [31:0]        INSTRUCTION;
    logic               BUSYWAIT;
    logic               WRITEENABLE;
    logic [ALUOP_W-1:0] ALUOP;
    logic               COMPLEMENT_FLAG;
    logic               IMMEDIATE_FLAG;
    logic               BRANCH_FLAG;
    logic               BNE_FLAG;
    logic               JUMP_FLAG;
    logic               READ;
    logic               WRITE;
    logic               LOAD_WORD_FLAG;
    logic               PC_STALL;
    logic               ILLEGAL;

    modport master (
        output INSTRUCTION, BUSYWAIT,
        input  WRITEENABLE, ALUOP, COMPLEMENT_FLAG, IMMEDIATE_FLAG,
        input  BRANCH_FLAG, BNE_FLAG, JUMP_FLAG, READ, WRITE,
        input  LOAD_WORD_FLAG, PC_STALL, ILLEGAL
    );

    modport slave (
        input  INSTRUCTION, BUSYWAIT,
        output WRITEENABLE, ALUOP, COMPLEMENT_FLAG, IMMEDIATE_FLAG,
        output BRANCH_FLAG, BNE_FLAG, JUMP_FLAG, READ, WRITE,
        output LOAD_WORD_FLAG, PC_STALL, ILLEGAL
    );
endinterface

// File: rtl/ctrl_unit_seq.sv
// Sequenced control unit: registered opcode decode with memory and
// multi-cycle multiply stalls, and a sticky illegal-opcode halt.
module ctrl_unit_seq #(
    parameter int ALUOP_W     = 3,
    parameter int MULT_CYCLES = 4,
    parameter bit ENABLE_EXT  = 1'b1
) (
    input logic            CLK,
    input logic            RESET,
    ctrl_unit_seq_if.slave bus
);
    localparam int CW         = $clog2(MULT_CYCLES) + 1;
    localparam int CNT_INIT_I = (MULT_CYCLES > 1) ? MULT_CYCLES - 2 : 0;
    localparam bit MULTI      = (MULT_CYCLES > 1);

    typedef enum logic [1:0] {RUN, MEM, MULT, HALT} state_t;

    typedef struct packed {
        logic       we;
        logic [2:0] aluop;
        logic       comp;
        logic       imm;
        logic       br;
        logic       bne;
        logic       jmp;
        logic       rd;
        logic       wr;
        logic       lwf;
        logic       stall;
        logic       ill;
    } ctrl_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    ctrl_t         q, d, dec, halt_v;
    logic [7:0]    op;
    logic          legal;
    logic          is_mem;
    logic          is_mult;
    logic          unused_lo;

    assign op        = bus.INSTRUCTION[31:24];
    assign unused_lo = ^bus.INSTRUCTION[23:0];
    assign is_mem    = (op >= 8'h08) && (op <= 8'h0B);
    assign is_mult   = (op == 8'h0F);

    always_comb begin
        halt_v       = '0;
        halt_v.ill   = 1'b1;
        halt_v.stall = 1'b1;
    end

    always_comb begin
        dec   = '0;
        legal = 1'b1;
        unique case (op)
            8'h00: begin dec.we = 1'b1; dec.imm = 1'b1; end
            8'h01: dec.we = 1'b1;
            8'h02: begin dec.we = 1'b1; dec.aluop = 3'b001; end
            8'h03: begin
                dec.we    = 1'b1;
                dec.comp  = 1'b1;
                dec.aluop = 3'b001;
            end
            8'h04: begin dec.we = 1'b1; dec.aluop = 3'b010; end
            8'h05: begin dec.we = 1'b1; dec.aluop = 3'b011; end
            8'h06: dec.jmp = 1'b1;
            8'h07: begin
                dec.br    = 1'b1;
                dec.comp  = 1'b1;
                dec.aluop = 3'b001;
            end
            8'h08: begin dec.rd = 1'b1; dec.lwf = 1'b1; end
            8'h09: begin
                dec.rd  = 1'b1;
                dec.lwf = 1'b1;
                dec.imm = 1'b1;
            end
            8'h0A: dec.wr = 1'b1;
            8'h0B: begin dec.wr = 1'b1; dec.imm = 1'b1; end
            8'h0C: begin dec.we = 1'b1; dec.aluop = 3'b100; end
            8'h0D: begin dec.we = 1'b1; dec.aluop = 3'b101; end
            8'h0E: begin
                dec.br    = 1'b1;
                dec.bne   = 1'b1;
                dec.comp  = 1'b1;
                dec.aluop = 3'b001;
            end
            8'h0F: dec.aluop = 3'b110;
            default: legal = 1'b0;
        endcase
        if (!ENABLE_EXT && op >= 8'h0C && op <= 8'h0F) begin
            legal = 1'b0;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        d       = q;
        unique case (state)
            RUN: begin
                d = dec;
                if (!legal) begin
                    d       = halt_v;
                    state_n = HALT;
                end else if (is_mem) begin
                    d.stall = 1'b1;
                    state_n = MEM;
                end else if (is_mult && MULTI) begin
                    d.stall = 1'b1;
                    cnt_n   = CW'(CNT_INIT_I);
                    state_n = MULT;
                end else if (is_mult) begin
                    d.we = 1'b1;
                end
            end
            MEM: begin
                if (bus.BUSYWAIT) begin
                    d.we    = 1'b0;
                    d.stall = 1'b1;
                end else begin
                    // write-back only for loads; LWF stays up to steer it
                    d.rd    = 1'b0;
                    d.wr    = 1'b0;
                    d.we    = q.lwf;
                    d.stall = 1'b0;
                    state_n = RUN;
                end
            end
            MULT: begin
                d.aluop = 3'b110;
                if (cnt == '0) begin
                    d.we    = 1'b1;
                    d.stall = 1'b0;
                    state_n = RUN;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            HALT: d = halt_v;
            default: begin
                d       = halt_v;
                state_n = HALT;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= RUN;
            cnt   <= '0;
            q     <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            q     <= d;
        end
    end

    assign bus.WRITEENABLE     = q.we;
    assign bus.ALUOP           = ALUOP_W'(q.aluop);
    assign bus.COMPLEMENT_FLAG = q.comp;
    assign bus.IMMEDIATE_FLAG  = q.imm;
    assign bus.BRANCH_FLAG     = q.br;
    assign bus.BNE_FLAG        = q.bne;
    assign bus.JUMP_FLAG       = q.jmp;
    assign bus.READ            = q.rd;
    assign bus.WRITE           = q.wr;
    assign bus.LOAD_WORD_FLAG  = q.lwf;
    assign bus.PC_STALL        = q.stall;
    assign bus.ILLEGAL         = q.ill;
endmodule

// File: tb/tb_ctrl_unit_seq.sv
// Bench for ctrl_unit_seq: three builds (default, MULT_CYCLES=1,
// ENABLE_EXT=0) checked against a per-instruction trace model.
module tb_ctrl_unit_seq;
    typedef struct packed {
        logic       we;
        logic [2:0] aluop;
        logic       comp;
        logic       imm;
        logic       br;
        logic       bne;
        logic       jmp;
        logic       rd;
        logic       wr;
        logic       lwf;
        logic       stall;
        logic       ill;
    } vec_t;

    logic        CLK = 1'b0;
    logic        ra, rb, rc;
    logic [31:0] instr;
    logic        busy;
    int          checks = 0;
    int          errors = 0;
    int          sel = 0;
    vec_t        oa, ob, oc;

    ctrl_unit_seq_if ia ();
    ctrl_unit_seq_if ib ();
    ctrl_unit_seq_if ic ();

    assign ia.INSTRUCTION = instr;
    assign ib.INSTRUCTION = instr;
    assign ic.INSTRUCTION = instr;
    assign ia.BUSYWAIT    = busy;
    assign ib.BUSYWAIT    = busy;
    assign ic.BUSYWAIT    = busy;

    ctrl_unit_seq u_a (.CLK(CLK), .RESET(ra), .bus(ia.slave));
    ctrl_unit_seq #(.MULT_CYCLES(1)) u_b (
        .CLK(CLK), .RESET(rb), .bus(ib.slave)
    );
    ctrl_unit_seq #(.ENABLE_EXT(1'b0)) u_c (
        .CLK(CLK), .RESET(rc), .bus(ic.slave)
    );

    assign oa = {ia.WRITEENABLE, ia.ALUOP, ia.COMPLEMENT_FLAG,
                 ia.IMMEDIATE_FLAG, ia.BRANCH_FLAG, ia.BNE_FLAG,
                 ia.JUMP_FLAG, ia.READ, ia.WRITE, ia.LOAD_WORD_FLAG,
                 ia.PC_STALL, ia.ILLEGAL};
    assign ob = {ib.WRITEENABLE, ib.ALUOP, ib.COMPLEMENT_FLAG,
                 ib.IMMEDIATE_FLAG, ib.BRANCH_FLAG, ib.BNE_FLAG,
                 ib.JUMP_FLAG, ib.READ, ib.WRITE, ib.LOAD_WORD_FLAG,
                 ib.PC_STALL, ib.ILLEGAL};
    assign oc = {ic.WRITEENABLE, ic.ALUOP, ic.COMPLEMENT_FLAG,
                 ic.IMMEDIATE_FLAG, ic.BRANCH_FLAG, ic.BNE_FLAG,
                 ic.JUMP_FLAG, ic.READ, ic.WRITE, ic.LOAD_WORD_FLAG,
                 ic.PC_STALL, ic.ILLEGAL};

    always #5 CLK = ~CLK;

    function automatic vec_t cur();
        case (sel)
            0:       return oa;
            1:       return ob;
            default: return oc;
        endcase
    endfunction

    // Opcode table: the single-cycle control word of each instruction
    function automatic vec_t dec(input logic [7:0] op);
        vec_t v = '0;
        case (op)
            8'h00: begin v.we = 1; v.imm = 1; end
            8'h01: v.we = 1;
            8'h02: begin v.we = 1; v.aluop = 3'd1; end
            8'h03: begin v.we = 1; v.comp = 1; v.aluop = 3'd1; end
            8'h04: begin v.we = 1; v.aluop = 3'd2; end
            8'h05: begin v.we = 1; v.aluop = 3'd3; end
            8'h06: v.jmp = 1;
            8'h07: begin v.br = 1; v.comp = 1; v.aluop = 3'd1; end
            8'h08: begin v.rd = 1; v.lwf = 1; end
            8'h09: begin v.rd = 1; v.lwf = 1; v.imm = 1; end
            8'h0A: v.wr = 1;
            8'h0B: begin v.wr = 1; v.imm = 1; end
            8'h0C: begin v.we = 1; v.aluop = 3'd4; end
            8'h0D: begin v.we = 1; v.aluop = 3'd5; end
            8'h0E: begin
                v.br = 1; v.bne = 1; v.comp = 1; v.aluop = 3'd1;
            end
            8'h0F: v.aluop = 3'd6;
            default: ;
        endcase
        return v;
    endfunction

    task automatic check(input string tag, input vec_t exp,
                         input vec_t mask);
        vec_t o;
        o = cur();
        checks++;
        assert ((o & mask) === (exp & mask)) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, o, exp);
        end
    endtask

    task automatic set_rst(input logic v);
        case (sel)
            0:       ra = v;
            1:       rb = v;
            default: rc = v;
        endcase
    endtask

    task automatic pulse_reset(input string tag);
        set_rst(1'b1);
        @(posedge CLK); #1;
        check(tag, '0, '1);
        set_rst(1'b0);
    endtask

    // Build the whole expected cycle trace of one instruction, then play it
    task automatic do_op(input logic [7:0] op, input int b);
        vec_t e[$];
        vec_t m[$];
        vec_t full = '1;
        vec_t mk = '1;
        vec_t h = '0;
        vec_t v;
        int   mc = (sel == 1) ? 1 : 4;
        bit   ext = (sel != 2);
        bit   legal = (op <= 8'h0B) || (ext && op <= 8'h0F);
        bit   is_mem = legal && op >= 8'h08 && op <= 8'h0B;
        mk.imm = 1'b0;
        h.ill = 1'b1;
        h.stall = 1'b1;
        v = dec(op);
        if (!legal) begin
            repeat (12) begin e.push_back(h); m.push_back(full); end
        end else if (is_mem) begin
            v.stall = 1'b1;
            repeat (b + 1) begin e.push_back(v); m.push_back(full); end
            v.rd = 1'b0;
            v.wr = 1'b0;
            v.stall = 1'b0;
            v.we = (op <= 8'h09);
            e.push_back(v);
            m.push_back(mk);
        end else if (op == 8'h0F && mc > 1) begin
            v.stall = 1'b1;
            repeat (mc - 1) begin e.push_back(v); m.push_back(full); end
            v.stall = 1'b0;
            v.we = 1'b1;
            e.push_back(v);
            m.push_back(full);
        end else begin
            if (op == 8'h0F) v.we = 1'b1;
            e.push_back(v);
            m.push_back(full);
        end
        instr = {op, 24'($urandom)};
        for (int k = 0; k < e.size(); k++) begin
            if (is_mem) busy = (k >= 1 && k <= b);
            else busy = 1'($urandom);
            if (!legal && k > 0) instr = $urandom;
            @(posedge CLK); #1;
            check($sformatf("d%0d_op%02h_b%0d_c%0d", sel, op, b, k),
                  e[k], m[k]);
        end
        busy = 1'b0;
    endtask

    initial begin
        vec_t l, j;
        instr = '0;
        busy = 1'b0;
        ra = 1'b1;
        rb = 1'b1;
        rc = 1'b1;
        repeat (2) @(posedge CLK);
        #1;

        sel = 0;
        check("reset_a", '0, '1);
        ra = 1'b0;
        do_op(8'h02, 0);
        do_op(8'h03, 0);
        do_op(8'h08, 3);
        do_op(8'h0B, 0);
        do_op(8'h0F, 0);
        do_op(8'h0E, 0);
        do_op(8'h0C, 0);
        for (int i = 0; i < 60; i++) begin
            do_op(8'($urandom_range(0, 15)), $urandom_range(0, 3));
        end

        // reset lands in the second busy cycle of a load
        l = dec(8'h08);
        l.stall = 1'b1;
        j = dec(8'h06);
        instr = {8'h08, 24'h0};
        busy = 1'b0;
        @(posedge CLK); #1;
        check("lwd_abort_dec", l, '1);
        busy = 1'b1;
        @(posedge CLK); #1;
        check("lwd_abort_busy1", l, '1);
        ra = 1'b1;
        instr = {8'h06, 24'h0};
        @(posedge CLK); #1;
        check("lwd_abort_reset", '0, '1);
        ra = 1'b0;
        busy = 1'b0;
        repeat (3) begin
            @(posedge CLK); #1;
            check("lwd_abort_no_we", j, '1);
        end

        do_op(8'h20, 0);
        pulse_reset("halt_clear_a");
        do_op(8'h02, 0);

        sel = 1;
        ra = 1'b1;
        check("reset_b", '0, '1);
        rb = 1'b0;
        do_op(8'h0F, 0);
        do_op(8'h02, 0);
        do_op(8'h09, 1);
        for (int i = 0; i < 20; i++) begin
            do_op(8'($urandom_range(0, 15)), $urandom_range(0, 2));
        end

        sel = 2;
        rb = 1'b1;
        check("reset_c", '0, '1);
        rc = 1'b0;
        do_op(8'h02, 0);
        do_op(8'h0E, 0);
        pulse_reset("halt_clear_c");
        do_op(8'h0A, 2);
        do_op(8'h0F, 0);
        pulse_reset("halt_clear_c2");
        do_op(8'h03, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
